// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared constants and types for the 4x4 systolic array host feeder.
//   N          : array dimension (rows = columns = 4)
//   FEED_LEN   : cycles needed to push a skewed 4x4 operand pair in (2N-1)
//   ROW_STRIDE : flat-vector element stride between matrix rows
//   state_t    : feeder FSM states
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int N          = 4;
    localparam int FEED_LEN   = 2 * N - 1;
    localparam int ROW_STRIDE = 4;
    localparam int IDX_W      = $clog2(N);
    localparam int T_W        = 3;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_CLEAR   = 3'd1;
    localparam logic [2:0] ENC_FEED    = 3'd2;
    localparam logic [2:0] ENC_WAIT    = 3'd3;
    localparam logic [2:0] ENC_CAPTURE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_CLEAR   = ENC_CLEAR,
        ST_FEED    = ENC_FEED,
        ST_WAIT    = ENC_WAIT,
        ST_CAPTURE = ENC_CAPTURE
    } state_t;

endpackage

// File: rtl/systolic_skew_lane.sv
// ---------------------------------------------------------------------------
// systolic_skew_lane
// One edge lane of the array feed. Lane k presents element (t - k) of its
// row/column during feed step t, and zero outside the 4-cycle window, which
// produces the diagonal skew the array needs.
// Ports:
//   lane    in  IDX_W       lane index k (0..3)
//   t       in  T_W         feed step counter (0..6)
//   feed_en in  1           high only while the feeder is in FEED
//   elems   in  DW x N      latched row (left lanes) or column (up lanes)
//   skewed  out DW          element driven onto the array edge
// ---------------------------------------------------------------------------
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [IDX_W-1:0]      lane,
    input  logic [T_W-1:0]        t,
    input  logic                  feed_en,
    input  logic [DATA_WIDTH-1:0] elems [N],
    output logic [DATA_WIDTH-1:0] skewed
);

    logic [T_W:0] diff;

    // Extra top bit keeps t - lane from aliasing when t < lane; the window
    // check below only needs diff < 4 once t >= lane is known.
    assign diff = {1'b0, t} - {{(T_W + 1 - IDX_W){1'b0}}, lane};

    always_comb begin
        skewed = '0;
        if (feed_en && (t >= {{(T_W - IDX_W){1'b0}}, lane}) && (diff[T_W:IDX_W] == '0)) begin
            skewed = elems[diff[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Host-side driver for the 4x4 systolic matrix multiplier: latches A and B,
// resets the array, streams skewed rows/columns in, waits for the array's
// done and captures C = A*B.
// Ports:
//   clk_i       in   1          clock, rising edge
//   rst_ni      in   1          asynchronous active-low reset
//   start_i     in   1          job request, accepted in IDLE only
//   a_flat_i    in   16*DW      A[r][c] at [(4r+c)*DW +: DW]
//   b_flat_i    in   16*DW      B[r][c] at [(4r+c)*DW +: DW]
//   ready_o     out  1          high in IDLE
//   busy_o      out  1          ~ready_o
//   arr_rst_no  out  1          array reset (active low), low during CLEAR
//   left_o[4]   out  DW each    array left edge, rows 0..3
//   up_o[4]     out  DW each    array top edge, columns 0..3
//   done_i      in   1          array done (only honoured in WAIT)
//   res_flat_i  in   16*2DW     array results, element k at [k*2DW +: 2DW]
//   res_flat_o  out  16*2DW     captured results, held until next capture
//   valid_o     out  1          one-cycle pulse, high while res_flat_o is new
//   err_o       out  1          sticky done timeout, cleared on next start
// ---------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [N*N*DATA_WIDTH-1:0]      a_flat_i,
    input  logic [N*N*DATA_WIDTH-1:0]      b_flat_i,
    output logic                           ready_o,
    output logic                           busy_o,
    output logic                           arr_rst_no,
    output logic [DATA_WIDTH-1:0]          left_o [N],
    output logic [DATA_WIDTH-1:0]          up_o [N],
    input  logic                           done_i,
    input  logic [N*N*2*DATA_WIDTH-1:0]    res_flat_i,
    output logic [N*N*2*DATA_WIDTH-1:0]    res_flat_o,
    output logic                           valid_o,
    output logic                           err_o
);

    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
    localparam logic [T_W-1:0]    FEED_LAST = T_W'(FEED_LEN - 1);

    state_t                      state;
    state_t                      state_next;
    logic [T_W-1:0]              t_cnt;
    logic [WAIT_W-1:0]           wait_cnt;
    logic [N*N*DATA_WIDTH-1:0]   a_lat;
    logic [N*N*DATA_WIDTH-1:0]   b_lat;
    logic                        accept;
    logic                        feed_en;
    logic                        timeout;
    logic [DATA_WIDTH-1:0]       a_row [N][N];
    logic [DATA_WIDTH-1:0]       b_col [N][N];

    // Next-state logic and the purely state-decoded outputs.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (start_i) state_next = ST_CLEAR;
            ST_CLEAR:   state_next = ST_FEED;
            ST_FEED:    if (t_cnt == FEED_LAST) state_next = ST_WAIT;
            ST_WAIT: begin
                if (done_i) begin
                    state_next = ST_CAPTURE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign ready_o = (state == ST_IDLE);
    assign busy_o  = ~ready_o;
    assign valid_o = (state == ST_CAPTURE);
    assign feed_en = (state == ST_FEED);
    assign accept  = (state == ST_IDLE) && start_i;
    assign timeout = (state == ST_WAIT) && !done_i && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Feed step and wait counters restart from zero every time their state is entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_cnt    <= '0;
            wait_cnt <= '0;
        end else begin
            t_cnt    <= (state == ST_FEED && state_next == ST_FEED) ? t_cnt + 1'b1 : '0;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Operands are captured on acceptance so the host may change its inputs mid-job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_lat <= '0;
            b_lat <= '0;
        end else if (accept) begin
            a_lat <= a_flat_i;
            b_lat <= b_flat_i;
        end
    end

    // arr_rst_no is registered from the next state so it is low exactly for the
    // CLEAR cycle and glitch-free towards the array. Results are taken on the
    // done edge so res_flat_o already holds C while valid_o is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arr_rst_no <= 1'b0;
            res_flat_o <= '0;
            err_o      <= 1'b0;
        end else begin
            arr_rst_no <= (state_next != ST_CLEAR);
            if (state == ST_WAIT && done_i) begin
                res_flat_o <= res_flat_i;
            end
            if (accept) begin
                err_o <= 1'b0;
            end else if (timeout) begin
                err_o <= 1'b1;
            end
        end
    end

    // Left lane i carries row i of A; up lane j carries column j of B.
    for (genvar r = 0; r < N; r++) begin : g_unpack_row
        for (genvar c = 0; c < N; c++) begin : g_unpack_col
            assign a_row[r][c] = a_lat[(r*ROW_STRIDE+c)*DATA_WIDTH +: DATA_WIDTH];
            assign b_col[c][r] = b_lat[(r*ROW_STRIDE+c)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lanes
        systolic_skew_lane #(.DATA_WIDTH(DATA_WIDTH)) u_left (
            .lane    (IDX_W'(i)),
            .t       (t_cnt),
            .feed_en (feed_en),
            .elems   (a_row[i]),
            .skewed  (left_o[i])
        );
        systolic_skew_lane #(.DATA_WIDTH(DATA_WIDTH)) u_up (
            .lane    (IDX_W'(i)),
            .t       (t_cnt),
            .feed_en (feed_en),
            .elems   (b_col[i]),
            .skewed  (up_o[i])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
// Directed sequence with random operands around systolic_feeder, with a
// behavioural 4x4 systolic array attached to its outputs. Expected results
// come from a plain matrix multiply of the operands the bench applied.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int DW  = 32;
    localparam int RW  = 2 * DW;
    localparam int WL  = 16;
    localparam int DONE_AT = 11;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [16*DW-1:0]      a_flat;
    logic [16*DW-1:0]      b_flat;
    logic                  ready;
    logic                  busy;
    logic                  arr_rst_n;
    logic [DW-1:0]         left [4];
    logic [DW-1:0]         up [4];
    logic                  done = 1'b0;
    logic [16*RW-1:0]      res_in = '0;
    logic [16*RW-1:0]      res_out;
    logic                  valid;
    logic                  err;

    int checks   = 0;
    int failures = 0;
    bit done_stuck = 1'b0;

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .a_flat_i   (a_flat),
        .b_flat_i   (b_flat),
        .ready_o    (ready),
        .busy_o     (busy),
        .arr_rst_no (arr_rst_n),
        .left_o     (left),
        .up_o       (up),
        .done_i     (done),
        .res_flat_i (res_in),
        .res_flat_o (res_out),
        .valid_o    (valid),
        .err_o      (err)
    );

    // Behavioural array: PE(i,j) multiplies the left stream delayed by j and the
    // up stream delayed by i; done fires DONE_AT cycles after reset release and
    // then every 16 cycles, like the real free-running counter.
    logic [DW-1:0] left_hist [4][32];
    logic [DW-1:0] up_hist [4][32];
    logic [RW-1:0] acc [16];
    int arr_cycle = 0;

    always @(negedge clk) begin
        if (arr_rst_n !== 1'b1) begin
            arr_cycle = 0;
            for (int k = 0; k < 16; k++) acc[k] = '0;
        end else begin
            if (arr_cycle < 32) begin
                for (int i = 0; i < 4; i++) begin
                    left_hist[i][arr_cycle] = left[i];
                    up_hist[i][arr_cycle]   = up[i];
                end
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        logic [DW-1:0] lv;
                        logic [DW-1:0] uv;
                        lv = (arr_cycle - j >= 0) ? left_hist[i][arr_cycle-j] : '0;
                        uv = (arr_cycle - i >= 0) ? up_hist[j][arr_cycle-i] : '0;
                        acc[4*i+j] = acc[4*i+j] + {{DW{1'b0}}, lv} * {{DW{1'b0}}, uv};
                    end
                end
            end
            arr_cycle++;
        end
        for (int k = 0; k < 16; k++) res_in[k*RW +: RW] = acc[k];
        done = !done_stuck && (arr_cycle >= DONE_AT) && (((arr_cycle - DONE_AT) % 16) == 0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [16*RW-1:0] mat_mul(input logic [16*DW-1:0] a, input logic [16*DW-1:0] b);
        logic [16*RW-1:0] c;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                logic [RW-1:0] sum;
                sum = '0;
                for (int m = 0; m < 4; m++) begin
                    sum = sum + {{DW{1'b0}}, a[(4*r+m)*DW +: DW]} * {{DW{1'b0}}, b[(4*m+col)*DW +: DW]};
                end
                c[(4*r+col)*RW +: RW] = sum;
            end
        end
        return c;
    endfunction

    function automatic logic [16*DW-1:0] rand_mat();
        logic [16*DW-1:0] m;
        for (int k = 0; k < 16; k++) m[k*DW +: DW] = $urandom;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [16*RW-1:0] exp);
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("%s_row%0d", tag, r), res_out[r*4*RW +: 4*RW], exp[r*4*RW +: 4*RW]);
        end
    endtask

    // Presents operands with start for one negedge-to-negedge cycle; on return
    // the bench sits in the CLEAR cycle of the accepted job.
    task automatic applyStimulus(input logic [16*DW-1:0] a, input logic [16*DW-1:0] b, input bit hold);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_valid_seen"}, 256'(found), 256'(1));
    endtask

    task automatic runJob(input string tag, input logic [16*DW-1:0] a, input logic [16*DW-1:0] b);
        applyStimulus(a, b, 1'b0);
        waitValid(tag);
        @(negedge clk);
        checkOutput({tag, "_valid_pulse_ends"}, 256'(valid), 256'(0));
        checkResult(tag, mat_mul(a, b));
        checkOutput({tag, "_err"}, 256'(err), 256'(0));
    endtask

    logic [16*DW-1:0] a_m, b_m, a2_m, b2_m;
    logic [16*RW-1:0] prev_res;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_flat = '0;
        b_flat = '0;
        #12;
        checkOutput("reset_ready", 256'(ready), 256'(1));
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_arr_rst", 256'(arr_rst_n), 256'(0));
        checkOutput("reset_valid", 256'(valid), 256'(0));
        checkOutput("reset_err", 256'(err), 256'(0));
        checkOutput("reset_res_nonzero", 256'(|res_out), 256'(0));
        checkOutput("reset_lanes", {left[0], left[1], left[2], left[3], up[0], up[1], up[2], up[3]}, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_arr_rst", 256'(arr_rst_n), 256'(1));

        // 1: identity times counting matrix
        $display("[TB] job 1: identity");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a_m[(4*r+c)*DW +: DW] = (r == c) ? DW'(1) : DW'(0);
                b_m[(4*r+c)*DW +: DW] = DW'(4*r + c + 1);
            end
        end
        runJob("t1", a_m, b_m);

        // 2: constant matrices, with edge skew checked step by step
        $display("[TB] job 2: constant operands and skew");
        for (int k = 0; k < 16; k++) begin
            a_m[k*DW +: DW] = DW'(2);
            b_m[k*DW +: DW] = DW'(3);
        end
        applyStimulus(a_m, b_m, 1'b0);
        checkOutput("t2_clear_arr_rst", 256'(arr_rst_n), 256'(0));
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_left3_t%0d", t), 256'(left[3]), 256'((t >= 3) ? 2 : 0));
            checkOutput($sformatf("t2_up0_t%0d", t), 256'(up[0]), 256'((t <= 3) ? 3 : 0));
        end
        waitValid("t2");
        @(negedge clk);
        checkResult("t2", mat_mul(a_m, b_m));

        // 3: start during FEED and WAIT is ignored; inputs change after acceptance
        $display("[TB] job 3: ignored starts");
        a_m = rand_mat();
        b_m = rand_mat();
        begin
            int vcount;
            int vfirst;
            vcount = 0;
            vfirst = 0;
            applyStimulus(a_m, b_m, 1'b0);
            a_flat = rand_mat();
            b_flat = rand_mat();
            for (int n = 1; n <= 40; n++) begin
                if (vfirst == 0) checkOutput($sformatf("t3_ready_n%0d", n), 256'(ready), 256'(0));
                if (vfirst != 0 && n == vfirst + 1) begin
                    checkResult("t3", mat_mul(a_m, b_m));
                    checkOutput("t3_ready_after", 256'(ready), 256'(1));
                end
                if (valid === 1'b1) begin
                    vcount++;
                    if (vfirst == 0) vfirst = n;
                end
                start = (n == 3) || (n == 10);
                @(negedge clk);
            end
            start = 1'b0;
            checkOutput("t3_valid_count", 256'(vcount), 256'(1));
        end

        // 4: reset in the middle of FEED
        $display("[TB] job 4: reset mid-feed");
        applyStimulus(rand_mat(), rand_mat(), 1'b0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t4_ready", 256'(ready), 256'(1));
        checkOutput("t4_arr_rst", 256'(arr_rst_n), 256'(0));
        checkOutput("t4_lanes", {left[0], left[1], left[2], left[3], up[0], up[1], up[2], up[3]}, 256'(0));
        checkOutput("t4_res_nonzero", 256'(|res_out), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_m = rand_mat();
        b_m = rand_mat();
        runJob("t4", a_m, b_m);
        prev_res = mat_mul(a_m, b_m);

        // 5: done never arrives
        $display("[TB] job 5: done timeout");
        done_stuck = 1'b1;
        begin
            int busy_cycles;
            int vcount;
            busy_cycles = 1;
            vcount = 0;
            applyStimulus(rand_mat(), rand_mat(), 1'b0);
            for (int k = 0; k < 60; k++) begin
                if (valid === 1'b1) vcount++;
                @(negedge clk);
                if (ready === 1'b1) break;
                busy_cycles++;
            end
            checkOutput("t5_busy_cycles", 256'(busy_cycles), 256'(1 + 7 + WL));
            checkOutput("t5_err", 256'(err), 256'(1));
            checkOutput("t5_busy", 256'(busy), 256'(0));
            checkOutput("t5_valid_count", 256'(vcount), 256'(0));
            checkResult("t5_retained", prev_res);
        end
        done_stuck = 1'b0;
        @(negedge clk);
        a_m = rand_mat();
        b_m = rand_mat();
        applyStimulus(a_m, b_m, 1'b0);
        checkOutput("t5_err_cleared", 256'(err), 256'(0));
        waitValid("t5b");
        @(negedge clk);
        checkResult("t5b", mat_mul(a_m, b_m));

        // 6: start held for two back-to-back jobs
        $display("[TB] job 6: back-to-back");
        a_m  = rand_mat();
        b_m  = rand_mat();
        a2_m = rand_mat();
        b2_m = rand_mat();
        applyStimulus(a_m, b_m, 1'b1);
        a_flat = a2_m;
        b_flat = b2_m;
        waitValid("t6a");
        @(negedge clk);
        checkResult("t6a", mat_mul(a_m, b_m));
        checkOutput("t6_idle_gap", 256'(ready), 256'(1));
        @(negedge clk);
        checkOutput("t6_reaccept", 256'(ready), 256'(0));
        start = 1'b0;
        waitValid("t6b");
        @(negedge clk);
        checkResult("t6b", mat_mul(a2_m, b2_m));
        checkOutput("t6_err", 256'(err), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
